// File: rtl/cp0_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : cp0_pkg                                                        |
// | Description : Shared CP0 register numbers, vectors and SR/Cause field layout |
// | Revision    : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
package cp0_pkg;

    localparam logic [4:0]  CP0_REG_SR    = 5'd12;
    localparam logic [4:0]  CP0_REG_CAUSE = 5'd13;
    localparam logic [4:0]  CP0_REG_EPC   = 5'd14;
    localparam logic [4:0]  CP0_REG_PRID  = 5'd15;

    localparam logic [31:0] HANDLER_VEC   = 32'h0000_4180;
    localparam logic [31:0] RESET_PC      = 32'h0000_3000;

    localparam int SR_IE_BIT     = 0;
    localparam int SR_EXL_BIT    = 1;
    localparam int SR_IM_LSB     = 10;
    localparam int SR_IM_MSB     = 15;
    localparam int CAUSE_IP_LSB  = 10;
    localparam int CAUSE_IP_MSB  = 15;

    localparam logic [31:0] EPC_ALIGN_MASK = 32'hFFFF_FFFC;

    typedef struct packed {
        logic [5:0] im;
        logic       exl;
        logic       ie;
    } sr_t;

    function automatic logic [31:0] sr_pack(input sr_t sr);
        logic [31:0] w;
        w                       = '0;
        w[SR_IM_MSB:SR_IM_LSB]  = sr.im;
        w[SR_EXL_BIT]           = sr.exl;
        w[SR_IE_BIT]            = sr.ie;
        return w;
    endfunction

    function automatic logic [31:0] cause_pack(input logic [5:0] ip);
        logic [31:0] w;
        w                            = '0;
        w[CAUSE_IP_MSB:CAUSE_IP_LSB] = ip;
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cp0_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : cp0_if                                                         |
// | Description : Pipeline-side bus between the MEM stage / PC and CP0           |
// | Revision    : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
interface cp0_if;
    logic [4:0]  A1;
    logic [4:0]  A2;
    logic [31:0] DIn;
    logic        We;
    logic [31:0] PCM;
    logic        ValidM;
    logic [5:0]  HWInt;
    logic        EXLClr;
    logic        IntReq;
    logic [31:0] EPC;
    logic [31:0] DOut;

    modport master (
        output A1, A2, DIn, We, PCM, ValidM, HWInt, EXLClr,
        input  IntReq, EPC, DOut
    );

    modport slave (
        input  A1, A2, DIn, We, PCM, ValidM, HWInt, EXLClr,
        output IntReq, EPC, DOut
    );
endinterface
`default_nettype wire

// File: rtl/cp0.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : cp0                                                            |
// | Description : Coprocessor-0 interrupt controller (SR, Cause, EPC, PrID)      |
// | Revision    : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
module cp0
    import cp0_pkg::*;
#(
    parameter logic [31:0] PRID = 32'h0000_4D50
) (
    input  logic  clk,
    input  logic  reset,
    cp0_if.slave  bus
);

    sr_t         sr_q,  sr_d;
    logic [5:0]  ip_q,  ip_d;
    logic [31:0] epc_q, epc_d;
    logic        w_int_req;
    logic [31:0] w_dout;

    // Live HWInt is used so the request has zero-cycle latency.
    assign w_int_req = (|(bus.HWInt & sr_q.im)) & sr_q.ie & ~sr_q.exl & bus.ValidM;

    always_comb begin
        sr_d  = sr_q;
        epc_d = epc_q;
        ip_d  = bus.HWInt;
        if (w_int_req) begin
            // The victim's own mtc0 and any eret are dropped.
            sr_d.exl = 1'b1;
            epc_d    = bus.PCM & EPC_ALIGN_MASK;
        end else begin
            if (bus.We && (bus.A2 == CP0_REG_SR)) begin
                sr_d.im  = bus.DIn[SR_IM_MSB:SR_IM_LSB];
                sr_d.exl = bus.DIn[SR_EXL_BIT];
                sr_d.ie  = bus.DIn[SR_IE_BIT];
            end
            if (bus.We && (bus.A2 == CP0_REG_EPC)) begin
                epc_d = bus.DIn & EPC_ALIGN_MASK;
            end
            if (bus.EXLClr) begin
                sr_d.exl = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sr_q  <= '0;
            ip_q  <= '0;
            epc_q <= '0;
        end else begin
            sr_q  <= sr_d;
            ip_q  <= ip_d;
            epc_q <= epc_d;
        end
    end

    always_comb begin
        w_dout = '0;
        case (bus.A1)
            CP0_REG_SR:    w_dout = sr_pack(sr_q);
            CP0_REG_CAUSE: w_dout = cause_pack(ip_q);
            CP0_REG_EPC:   w_dout = epc_q;
            CP0_REG_PRID:  w_dout = PRID;
            default:       w_dout = '0;
        endcase
    end

    assign bus.IntReq = w_int_req;
    assign bus.EPC    = epc_q;
    assign bus.DOut   = w_dout;

endmodule
`default_nettype wire

// File: tb/tb_cp0.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_cp0                                                         |
// | Description : Directed + randomized self-checking bench for cp0             |
// | Revision    : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
module tb_cp0;

    localparam logic [31:0] C_PRID = 32'h0000_4D50;

    logic clk;
    logic reset;
    int   n_chk;
    int   n_err;

    cp0_if bus();

    cp0 #(.PRID(C_PRID)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference state, named after the architectural fields
    logic [5:0]  m_im, m_ip;
    logic        m_exl, m_ie;
    logic [31:0] m_epc;

    function automatic logic exp_intreq();
        return ((bus.HWInt & m_im) != 6'd0) && m_ie && !m_exl && bus.ValidM;
    endfunction

    function automatic logic [31:0] exp_read(input logic [4:0] a);
        case (a)
            5'd12:   return {16'b0, m_im, 8'b0, m_exl, m_ie};
            5'd13:   return {16'b0, m_ip, 10'b0};
            5'd14:   return m_epc;
            5'd15:   return C_PRID;
            default: return 32'h0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        #1;
        chk({tag, ".IntReq"}, {31'b0, bus.IntReq}, {31'b0, exp_intreq()});
        chk({tag, ".EPC"},    bus.EPC,             m_epc);
        chk({tag, ".DOut"},   bus.DOut,            exp_read(bus.A1));
    endtask

    task automatic rd(input string tag, input logic [4:0] a, input logic [31:0] exp);
        bus.A1 = a;
        #1;
        chk(tag, bus.DOut, exp);
    endtask

    // Advance one clock, applying the architectural rules to the model.
    task automatic tick();
        logic [5:0]  n_im;
        logic        n_exl, n_ie;
        logic [31:0] n_epc;
        logic        take;
        n_im  = m_im;
        n_exl = m_exl;
        n_ie  = m_ie;
        n_epc = m_epc;
        take  = exp_intreq();
        if (take) begin
            n_exl = 1'b1;
            n_epc = {bus.PCM[31:2], 2'b00};
        end else begin
            if (bus.We && bus.A2 == 5'd12) begin
                n_im  = bus.DIn[15:10];
                n_exl = bus.DIn[1];
                n_ie  = bus.DIn[0];
            end
            if (bus.We && bus.A2 == 5'd14) n_epc = {bus.DIn[31:2], 2'b00};
            if (bus.EXLClr) n_exl = 1'b0;
        end
        @(posedge clk);
        if (reset) begin
            m_im = '0; m_exl = 1'b0; m_ie = 1'b0; m_ip = '0; m_epc = '0;
        end else begin
            m_ip  = bus.HWInt;
            m_im  = n_im;
            m_exl = n_exl;
            m_ie  = n_ie;
            m_epc = n_epc;
        end
        #1;
    endtask

    task automatic idle_inputs();
        bus.A1 = 5'd0; bus.A2 = 5'd0; bus.DIn = '0; bus.We = 1'b0;
        bus.PCM = '0; bus.ValidM = 1'b0; bus.HWInt = '0; bus.EXLClr = 1'b0;
    endtask

    initial begin
        logic [4:0] a2_pick [5];
        n_chk = 0;
        n_err = 0;
        m_im = '0; m_ip = '0; m_exl = 1'b0; m_ie = 1'b0; m_epc = '0;
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;

        rd("rst.SR",    5'd12, 32'h0);
        rd("rst.Cause", 5'd13, 32'h0);
        rd("rst.EPC",   5'd14, 32'h0);
        rd("rst.PrID",  5'd15, 32'h0000_4D50);
        rd("rst.other", 5'd3,  32'h0);
        chk("rst.IntReq", {31'b0, bus.IntReq}, 32'h0);

        // Enable IM[0] and IE, then take an interrupt
        bus.We = 1'b1; bus.A2 = 5'd12; bus.DIn = 32'h0000_0401; bus.ValidM = 1'b1;
        tick();
        bus.We = 1'b0;
        bus.HWInt = 6'b000001; bus.PCM = 32'h0000_3010;
        #1 chk("irq.IntReq", {31'b0, bus.IntReq}, 32'h1);
        check_model("irq");
        tick();
        rd("irq.SR_after", 5'd12, 32'h0000_0403);
        chk("irq.EPC", bus.EPC, 32'h0000_3010);
        chk("irq.IntReq_after", {31'b0, bus.IntReq}, 32'h0);

        // eret
        bus.HWInt = '0; bus.EXLClr = 1'b1;
        check_model("eret");
        tick();
        bus.EXLClr = 1'b0;
        rd("eret.SR", 5'd12, 32'h0000_0401);
        chk("eret.EPC", bus.EPC, 32'h0000_3010);
        chk("eret.IntReq", {31'b0, bus.IntReq}, 32'h0);

        // Pending interrupt waits for a valid M instruction
        bus.HWInt = 6'b000001; bus.ValidM = 1'b0; bus.PCM = 32'h0000_3020;
        for (int i = 0; i < 3; i++) begin
            #1 chk("bubble.IntReq", {31'b0, bus.IntReq}, 32'h0);
            tick();
        end
        bus.ValidM = 1'b1; bus.PCM = 32'h0000_3026;
        #1 chk("valid.IntReq", {31'b0, bus.IntReq}, 32'h1);
        tick();
        chk("valid.EPC", bus.EPC, 32'h0000_3024);
        bus.HWInt = '0; bus.EXLClr = 1'b1;
        tick();
        bus.EXLClr = 1'b0;

        // Interrupt in the same slot as an mtc0 to EPC
        bus.HWInt = 6'b000001; bus.PCM = 32'h0000_3040;
        bus.We = 1'b1; bus.A2 = 5'd14; bus.DIn = 32'h0000_5000;
        check_model("victim");
        tick();
        bus.We = 1'b0;
        chk("victim.EPC", bus.EPC, 32'h0000_3040);
        bus.HWInt = '0; bus.EXLClr = 1'b1;
        tick();
        bus.EXLClr = 1'b0;

        // EPC alignment, and mfc0 in the same cycle returns the old value
        bus.We = 1'b1; bus.A2 = 5'd14; bus.DIn = 32'h0000_3007;
        tick();
        bus.DIn = 32'h0000_0100;
        rd("samecyc.EPC_old", 5'd14, 32'h0000_3004);
        tick();
        bus.We = 1'b0;
        rd("samecyc.EPC_new", 5'd14, 32'h0000_0100);

        // Masked line: no request, Cause still records it
        bus.HWInt = 6'b100000;
        #1 chk("masked.IntReq", {31'b0, bus.IntReq}, 32'h0);
        tick();
        rd("masked.Cause", 5'd13, 32'h0000_8000);

        // Reset while inside the handler
        bus.HWInt = 6'b000001; bus.PCM = 32'h0000_3080;
        tick();
        reset = 1'b1;
        #1 chk("rstmid.IntReq", {31'b0, bus.IntReq}, 32'h0);
        tick();
        reset = 1'b0;
        bus.HWInt = '0;
        rd("rstmid.SR", 5'd12, 32'h0);
        chk("rstmid.EPC", bus.EPC, 32'h0);

        // Randomized phase against the model
        a2_pick[0] = 5'd12; a2_pick[1] = 5'd12; a2_pick[2] = 5'd14;
        a2_pick[3] = 5'd13; a2_pick[4] = 5'd15;
        for (int i = 0; i < 400; i++) begin
            reset      = ($urandom_range(0, 63) == 0);
            bus.We     = ($urandom_range(0, 3) == 0);
            bus.A2     = ($urandom_range(0, 7) == 0) ? 5'($urandom) : a2_pick[$urandom_range(0, 4)];
            bus.DIn    = $urandom;
            if ($urandom_range(0, 1) == 0) bus.DIn[0] = 1'b1;
            bus.PCM    = $urandom;
            bus.ValidM = ($urandom_range(0, 3) != 0);
            bus.HWInt  = ($urandom_range(0, 2) == 0) ? 6'd0 : 6'($urandom);
            bus.EXLClr = ($urandom_range(0, 7) == 0);
            bus.A1     = 5'($urandom_range(10, 16));
            check_model("rand");
            tick();
        end
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
`default_nettype wire
